// File: rtl/memory_accessor.sv
// +----------------------------------------------------------------------------+
// | memory_accessor: executes MA packets as single 32-bit loads/stores and     |
// | emits a {dest, data} result token. Option: MEMORY_ACCESSOR_STORE_ACK_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module memory_accessor #(
   parameter int PACKET_WIDTH = 160,
   parameter int TOKEN_WIDTH  = 64
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [31:0]             BASEADDR,
   input  logic                    RECEIVE_PC_VALID,
   input  logic [PACKET_WIDTH-1:0] RECEIVE_PC_DATA,
   output logic                    RECEIVE_PC_READY,
   output logic                    MEM_SEND_ADDR_VALID,
   output logic [31:0]             MEM_SEND_ADDR,
   output logic                    MEM_SEND_DATA_VALID,
   output logic [31:0]             MEM_SEND_DATA,
   input  logic                    MEM_SEND_READY,
   input  logic                    MEM_RECEIVE_VALID,
   input  logic [31:0]             MEM_RECEIVE_DATA,
   output logic                    MEM_RECEIVE_READY,
   output logic                    SEND_TK_VALID,
   output logic [TOKEN_WIDTH-1:0]  SEND_TK_DATA,
   input  logic                    SEND_TK_READY,
   output logic                    ERR
);

   localparam logic [1:0] S_RECEIVE     = 2'd0;
   localparam logic [1:0] S_MEM_SEND    = 2'd1;
   localparam logic [1:0] S_MEM_RECEIVE = 2'd2;
   localparam logic [1:0] S_SEND        = 2'd3;

   localparam logic [1:0] c_MEMOP_LOAD  = 2'b00;
   localparam logic [1:0] c_MEMOP_STORE = 2'b01;

   logic [1:0]  r_state;
   logic        r_pc_ready;
   logic        r_addr_valid;
   logic        r_tk_valid;
   logic        r_err;
   logic [1:0]  r_memop;
   logic [31:0] r_dest;
   logic [31:0] r_offset;
   logic [31:0] r_sdata;
   logic [31:0] r_rdata;

   logic [1:0]  w_in_memop;
   logic        w_in_legal;
   logic        w_is_store;
   logic        w_is_legal;
   logic [31:0] w_tk_word;
   logic        w_unused;

   assign w_in_memop = RECEIVE_PC_DATA[PACKET_WIDTH-9 -: 2];
   assign w_in_legal = ~w_in_memop[1];
   assign w_is_store = (r_memop == c_MEMOP_STORE);
   assign w_is_legal = ~r_memop[1];

   // opmode, the low memop-word bits and word4 are carried but never used
   assign w_unused = &{1'b0, RECEIVE_PC_DATA[PACKET_WIDTH-1 -: 8],
                       RECEIVE_PC_DATA[PACKET_WIDTH-11 -: 22],
                       RECEIVE_PC_DATA[31:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_RECEIVE;
         r_pc_ready   <= 1'b0;
         r_addr_valid <= 1'b0;
         r_tk_valid   <= 1'b0;
         r_err        <= 1'b0;
         r_memop      <= c_MEMOP_LOAD;
         r_dest       <= '0;
         r_offset     <= '0;
         r_sdata      <= '0;
         r_rdata      <= '0;
      end else begin
         case (r_state)
            S_RECEIVE: begin
               if (r_pc_ready && RECEIVE_PC_VALID) begin
                  r_pc_ready <= 1'b0;
                  r_memop    <= w_in_memop;
                  r_dest     <= RECEIVE_PC_DATA[PACKET_WIDTH-33 -: 32];
                  r_offset   <= RECEIVE_PC_DATA[PACKET_WIDTH-65 -: 32];
                  r_sdata    <= RECEIVE_PC_DATA[PACKET_WIDTH-97 -: 32];
                  if (w_in_legal) begin
                     r_state <= S_MEM_SEND;
                  end else begin
                     r_state <= S_SEND;
                     r_err   <= 1'b1;
                  end
               end else begin
                  r_pc_ready <= 1'b1;
               end
            end
            S_MEM_SEND: begin
               if (r_addr_valid && MEM_SEND_READY) begin
                  r_addr_valid <= 1'b0;
`ifdef MEMORY_ACCESSOR_STORE_ACK_EN
                  r_state <= S_MEM_RECEIVE;
`else
                  r_state <= w_is_store ? S_SEND : S_MEM_RECEIVE;
`endif
               end else begin
                  r_addr_valid <= 1'b1;
               end
            end
            S_MEM_RECEIVE: begin
               if (MEM_RECEIVE_VALID) begin
                  // a store's ack carries no data worth keeping
                  if (!w_is_store) begin
                     r_rdata <= MEM_RECEIVE_DATA;
                  end
                  r_state <= S_SEND;
               end
            end
            default: begin
               if (r_tk_valid && SEND_TK_READY) begin
                  r_tk_valid <= 1'b0;
                  r_state    <= S_RECEIVE;
               end else begin
                  r_tk_valid <= 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_tk_word = r_rdata;
      if (!w_is_legal) begin
         w_tk_word = 32'hFFFF_FFFF;
      end else if (w_is_store) begin
         w_tk_word = r_sdata;
      end
   end

   assign RECEIVE_PC_READY    = r_pc_ready;
   assign MEM_SEND_ADDR_VALID = r_addr_valid;
   assign MEM_SEND_ADDR       = BASEADDR + r_offset;
   assign MEM_SEND_DATA_VALID = r_addr_valid & w_is_store;
   assign MEM_SEND_DATA       = r_sdata;
   assign MEM_RECEIVE_READY   = 1'b1;
   assign SEND_TK_VALID       = r_tk_valid;
   assign SEND_TK_DATA        = {r_dest, w_tk_word};
   assign ERR                 = r_err;

endmodule

`default_nettype wire

// File: tb/tb_memory_accessor.sv
// +----------------------------------------------------------------------------+
// | tb_memory_accessor: directed self-checking bench for memory_accessor.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_memory_accessor;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [31:0]  BASEADDR = '0;
   logic         RECEIVE_PC_VALID = 1'b0;
   logic [159:0] RECEIVE_PC_DATA = '0;
   logic         RECEIVE_PC_READY;
   logic         MEM_SEND_ADDR_VALID;
   logic [31:0]  MEM_SEND_ADDR;
   logic         MEM_SEND_DATA_VALID;
   logic [31:0]  MEM_SEND_DATA;
   logic         MEM_SEND_READY = 1'b0;
   logic         MEM_RECEIVE_VALID = 1'b0;
   logic [31:0]  MEM_RECEIVE_DATA = '0;
   logic         MEM_RECEIVE_READY;
   logic         SEND_TK_VALID;
   logic [63:0]  SEND_TK_DATA;
   logic         SEND_TK_READY = 1'b0;
   logic         ERR;

   int n_checks = 0;
   int n_errors = 0;
   int req_cnt = 0;
   int tk_cnt = 0;
   int av_cycles = 0;

   always #5 CLK = ~CLK;

   memory_accessor dut (
      .CLK                 (CLK),
      .RST                 (RST),
      .BASEADDR            (BASEADDR),
      .RECEIVE_PC_VALID    (RECEIVE_PC_VALID),
      .RECEIVE_PC_DATA     (RECEIVE_PC_DATA),
      .RECEIVE_PC_READY    (RECEIVE_PC_READY),
      .MEM_SEND_ADDR_VALID (MEM_SEND_ADDR_VALID),
      .MEM_SEND_ADDR       (MEM_SEND_ADDR),
      .MEM_SEND_DATA_VALID (MEM_SEND_DATA_VALID),
      .MEM_SEND_DATA       (MEM_SEND_DATA),
      .MEM_SEND_READY      (MEM_SEND_READY),
      .MEM_RECEIVE_VALID   (MEM_RECEIVE_VALID),
      .MEM_RECEIVE_DATA    (MEM_RECEIVE_DATA),
      .MEM_RECEIVE_READY   (MEM_RECEIVE_READY),
      .SEND_TK_VALID       (SEND_TK_VALID),
      .SEND_TK_DATA        (SEND_TK_DATA),
      .SEND_TK_READY       (SEND_TK_READY),
      .ERR                 (ERR)
   );

   always @(posedge CLK) begin
      if (MEM_SEND_ADDR_VALID && MEM_SEND_READY) req_cnt <= req_cnt + 1;
      if (SEND_TK_VALID && SEND_TK_READY) tk_cnt <= tk_cnt + 1;
      if (MEM_SEND_ADDR_VALID) av_cycles <= av_cycles + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
      int n;
      n = 0;
      RECEIVE_PC_VALID = 1'b1;
      RECEIVE_PC_DATA  = {w0, w1, w2, w3, 32'h5A5A_5A5A};
      while (!RECEIVE_PC_READY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      check_eq({tag, "_pc_ready"}, RECEIVE_PC_READY, 1);
      @(negedge CLK);
      RECEIVE_PC_VALID = 1'b0;
      RECEIVE_PC_DATA  = '0;
   endtask

   task automatic serve_mem(input string tag, input logic [31:0] exp_addr, input bit is_store,
                            input logic [31:0] exp_sdata, input logic [31:0] rdata,
                            input int stall, input bit respond);
      int  waits;
      bit  need_resp;
      waits = 0;
      while (!MEM_SEND_ADDR_VALID && waits < 50) begin
         @(negedge CLK);
         waits++;
      end
      check_eq({tag, "_addr_valid"}, MEM_SEND_ADDR_VALID, 1);
      check_eq({tag, "_addr_lat"}, waits, 1);
      check_eq({tag, "_addr"}, MEM_SEND_ADDR, exp_addr);
      check_eq({tag, "_data_valid"}, MEM_SEND_DATA_VALID, is_store);
      if (is_store) check_eq({tag, "_sdata"}, MEM_SEND_DATA, exp_sdata);
      for (int i = 0; i < stall; i++) begin
         // stray response while the request is still pending must be ignored
         MEM_RECEIVE_VALID = (i == 0);
         MEM_RECEIVE_DATA  = 32'hBAD0_BAD0;
         @(negedge CLK);
         MEM_RECEIVE_VALID = 1'b0;
         check_eq({tag, "_hold_valid"}, MEM_SEND_ADDR_VALID, 1);
         check_eq({tag, "_hold_addr"}, MEM_SEND_ADDR, exp_addr);
         check_eq({tag, "_hold_dvalid"}, MEM_SEND_DATA_VALID, is_store);
      end
      MEM_SEND_READY = 1'b1;
      @(negedge CLK);
      MEM_SEND_READY = 1'b0;
      check_eq({tag, "_addr_drop"}, MEM_SEND_ADDR_VALID, 0);
      need_resp = !is_store;
`ifdef MEMORY_ACCESSOR_STORE_ACK_EN
      need_resp = 1'b1;
      if (is_store) begin
         repeat (3) @(negedge CLK);
         check_eq({tag, "_no_tk_before_ack"}, SEND_TK_VALID, 0);
      end
`endif
      if (need_resp && respond) begin
         MEM_RECEIVE_VALID = 1'b1;
         MEM_RECEIVE_DATA  = rdata;
         @(negedge CLK);
         MEM_RECEIVE_VALID = 1'b0;
         MEM_RECEIVE_DATA  = '0;
      end
   endtask

   task automatic get_token(input string tag, input logic [63:0] exp, input int stall);
      int waits;
      waits = 0;
      while (!SEND_TK_VALID && waits < 50) begin
         @(negedge CLK);
         waits++;
      end
      check_eq({tag, "_tk_valid"}, SEND_TK_VALID, 1);
      check_eq({tag, "_tk_lat"}, waits, 1);
      check_eq({tag, "_tk_data"}, SEND_TK_DATA, exp);
      for (int i = 0; i < stall; i++) begin
         @(negedge CLK);
         check_eq({tag, "_tk_hold_valid"}, SEND_TK_VALID, 1);
         check_eq({tag, "_tk_hold_data"}, SEND_TK_DATA, exp);
      end
      SEND_TK_READY = 1'b1;
      @(negedge CLK);
      SEND_TK_READY = 1'b0;
      check_eq({tag, "_tk_drop"}, SEND_TK_VALID, 0);
   endtask

   initial begin
      int req0, tk0, av0;

      repeat (3) @(negedge CLK);
      check_eq("rst_pc_ready", RECEIVE_PC_READY, 0);
      check_eq("rst_addr_valid", MEM_SEND_ADDR_VALID, 0);
      check_eq("rst_data_valid", MEM_SEND_DATA_VALID, 0);
      check_eq("rst_tk_valid", SEND_TK_VALID, 0);
      check_eq("rst_err", ERR, 0);
      check_eq("rst_mem_rx_ready", MEM_RECEIVE_READY, 1);
      RST = 1'b0;
      @(negedge CLK);
      check_eq("idle_pc_ready", RECEIVE_PC_READY, 1);
      MEM_RECEIVE_VALID = 1'b1;
      MEM_RECEIVE_DATA  = 32'h0BAD_0BAD;
      @(negedge CLK);
      MEM_RECEIVE_VALID = 1'b0;
      check_eq("idle_stray_ignored", RECEIVE_PC_READY, 1);

      // load
      BASEADDR = 32'h0000_1000;
      push_pkt("ld", 32'h0A00_0000, 32'hA5, 32'h20, 32'h0);
      serve_mem("ld", 32'h0000_1020, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
      get_token("ld", 64'h0000_00A5_DEAD_BEEF, 0);
      check_eq("ld_err", ERR, 0);

      // store
      push_pkt("st", 32'h0A40_0000, 32'h7, 32'h4, 32'h1234_5678);
      serve_mem("st", 32'h0000_1004, 1'b1, 32'h1234_5678, 32'hFEED_0000, 0, 1'b1);
      get_token("st", 64'h0000_0007_1234_5678, 0);
      check_eq("st_err", ERR, 0);

      // illegal memop 10
      av0 = av_cycles;
      push_pkt("il", 32'h0A80_0000, 32'h33, 32'h8, 32'h9);
      get_token("il", 64'h0000_0033_FFFF_FFFF, 0);
      check_eq("il_err", ERR, 1);
      check_eq("il_no_req", av_cycles - av0, 0);

      // back-pressure on both sides
      req0 = req_cnt;
      tk0  = tk_cnt;
      BASEADDR = 32'h0000_2000;
      push_pkt("bp", 32'h0A00_0000, 32'h55, 32'h100, 32'h0);
      serve_mem("bp", 32'h0000_2100, 1'b0, 32'h0, 32'hCAFE_F00D, 5, 1'b1);
      get_token("bp", 64'h0000_0055_CAFE_F00D, 7);
      repeat (3) @(negedge CLK);
      check_eq("bp_one_req", req_cnt - req0, 1);
      check_eq("bp_one_tk", tk_cnt - tk0, 1);
      check_eq("bp_err_sticky", ERR, 1);

      // address wrap
      BASEADDR = 32'hFFFF_FFF0;
      push_pkt("wr", 32'h0A40_0000, 32'h9, 32'h20, 32'hAABB_CCDD);
      serve_mem("wr", 32'h0000_0010, 1'b1, 32'hAABB_CCDD, 32'h0, 0, 1'b1);
      get_token("wr", 64'h0000_0009_AABB_CCDD, 0);
      check_eq("wr_err_sticky", ERR, 1);

      // reset while waiting for read data
      tk0 = tk_cnt;
      BASEADDR = 32'h0;
      push_pkt("rs", 32'h0A00_0000, 32'h44, 32'h40, 32'h0);
      serve_mem("rs", 32'h0000_0040, 1'b0, 32'h0, 32'h0, 0, 1'b0);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check_eq("rs_addr_valid", MEM_SEND_ADDR_VALID, 0);
      check_eq("rs_data_valid", MEM_SEND_DATA_VALID, 0);
      check_eq("rs_tk_valid", SEND_TK_VALID, 0);
      check_eq("rs_pc_ready_lo", RECEIVE_PC_READY, 0);
      check_eq("rs_err_clear", ERR, 0);
      @(negedge CLK);
      check_eq("rs_pc_ready_hi", RECEIVE_PC_READY, 1);
      repeat (5) @(negedge CLK);
      check_eq("rs_no_tk", tk_cnt - tk0, 0);
      check_eq("rs_tk_idle", SEND_TK_VALID, 0);

      // recovery after reset
      push_pkt("rc", 32'h0A00_0000, 32'h11, 32'h8, 32'h0);
      serve_mem("rc", 32'h0000_0008, 1'b0, 32'h0, 32'h0102_0304, 0, 1'b1);
      get_token("rc", 64'h0000_0011_0102_0304, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
